// File: rtl/dyn_pattern_det_pkg.sv
// dyn_pattern_det_pkg
//   Shared types and constants for the programmable sequence detector.
//   state_t  : detector FSM states (off / filling history / armed)
//   DEF_LEN  : pattern length held after reset (0 = unprogrammed)
//   DEF_OVL  : overlap mode held after reset
package dyn_pattern_det_pkg;

    typedef enum logic [1:0] {
        S_OFF,
        S_FILL,
        S_ARMED
    } state_t;

    localparam int unsigned DEF_LEN = 0;
    localparam logic        DEF_OVL = 1'b1;

endpackage

// File: rtl/dyn_pattern_det_pat_cmp.sv
// pat_cmp
//   Combinational masked compare of the candidate history against the
//   programmed pattern. Only symbols 0..len-1 take part; higher symbols
//   are ignored.
//   Ports:
//     hist_next : history including the symbol being accepted (newest at 0)
//     pat       : programmed pattern, symbol k at [k*SYM_W +: SYM_W]
//     len       : programmed length in symbols
//     match     : 1 when every enabled symbol is equal
module pat_cmp #(
    parameter int unsigned SYM_W   = 1,
    parameter int unsigned MAX_LEN = 8,
    parameter int unsigned LEN_W   = $clog2(MAX_LEN + 1)
) (
    input  logic [MAX_LEN*SYM_W-1:0] hist_next,
    input  logic [MAX_LEN*SYM_W-1:0] pat,
    input  logic [LEN_W-1:0]         len,
    output logic                     match
);

    always_comb begin
        match = 1'b1;
        for (int unsigned k = 0; k < MAX_LEN; k++) begin
            if ((LEN_W'(k) < len) &&
                (hist_next[k*SYM_W +: SYM_W] != pat[k*SYM_W +: SYM_W])) begin
                match = 1'b0;
            end
        end
    end

endmodule

// File: rtl/dyn_pattern_det.sv
// dyn_pattern_det
//   Runtime-programmable sequence detector on a valid-qualified symbol
//   stream, with overlapping / non-overlapping modes and a saturating
//   match counter.
//   Ports:
//     clk, rst      : clock, asynchronous active-low reset
//     cfg_we        : load cfg_pattern / cfg_len / cfg_overlap (beats valid_i)
//     cfg_pattern   : pattern, symbol cfg_len-1 arrives first, symbol 0 last
//     cfg_len       : pattern length in symbols (1..MAX_LEN legal)
//     cfg_overlap   : 1 = overlapping matches, 0 = non-overlapping
//     cnt_clr       : synchronous clear of match_count (beats increment)
//     valid_i, d_in : input symbol stream
//     pattern       : registered one-cycle match pulse
//     match_count   : saturating match count
//     cfg_err       : last loaded length was illegal
module dyn_pattern_det
    import dyn_pattern_det_pkg::*;
#(
    parameter int unsigned SYM_W   = 1,
    parameter int unsigned MAX_LEN = 8,
    parameter int unsigned LEN_W   = $clog2(MAX_LEN + 1),
    parameter int unsigned CNT_W   = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     cfg_we,
    input  logic [MAX_LEN*SYM_W-1:0] cfg_pattern,
    input  logic [LEN_W-1:0]         cfg_len,
    input  logic                     cfg_overlap,
    input  logic                     cnt_clr,
    input  logic                     valid_i,
    input  logic [SYM_W-1:0]         d_in,
    output logic                     pattern,
    output logic [CNT_W-1:0]         match_count,
    output logic                     cfg_err
);

    localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MAX_LEN);

    state_t                   state;
    logic [MAX_LEN*SYM_W-1:0] hist;
    logic [MAX_LEN*SYM_W-1:0] pat_r;
    logic [LEN_W-1:0]         len_r;
    logic [LEN_W-1:0]         fill;
    logic                     ovl_r;

    logic [MAX_LEN*SYM_W-1:0] hist_next;
    logic [LEN_W-1:0]         fill_next;
    logic                     accept;
    logic                     cmp_match;
    logic                     match_now;
    logic                     cfg_bad;

    // Shifting left drops the oldest symbol and puts the new one at index 0.
    assign hist_next = (hist << SYM_W) |
                       {{((MAX_LEN-1)*SYM_W){1'b0}}, d_in};
    assign fill_next = (fill == LEN_MAX) ? fill : fill + 1'b1;
    assign accept    = valid_i && !cfg_we && (state != S_OFF);
    assign match_now = accept && (fill_next >= len_r) && cmp_match;
    assign cfg_bad   = (cfg_len == '0) || (cfg_len > LEN_MAX);

    pat_cmp #(
        .SYM_W   (SYM_W),
        .MAX_LEN (MAX_LEN),
        .LEN_W   (LEN_W)
    ) u_pat_cmp (
        .hist_next (hist_next),
        .pat       (pat_r),
        .len       (len_r),
        .match     (cmp_match)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= S_OFF;
            hist        <= '0;
            fill        <= '0;
            pat_r       <= '0;
            len_r       <= LEN_W'(DEF_LEN);
            ovl_r       <= DEF_OVL;
            pattern     <= 1'b0;
            match_count <= '0;
            cfg_err     <= 1'b0;
        end else begin
            pattern <= 1'b0;

            if (cfg_we) begin
                pat_r   <= cfg_pattern;
                len_r   <= cfg_len;
                ovl_r   <= cfg_overlap;
                hist    <= '0;
                fill    <= '0;
                cfg_err <= cfg_bad;
                state   <= cfg_bad ? S_OFF : S_FILL;
            end else if (accept) begin
                hist    <= hist_next;
                pattern <= match_now;
                // Non-overlapping: a match consumes its symbols, so refill.
                if (match_now && !ovl_r) begin
                    fill  <= '0;
                    state <= S_FILL;
                end else begin
                    fill  <= fill_next;
                    state <= (fill_next >= len_r) ? S_ARMED : S_FILL;
                end
            end

            if (cnt_clr) begin
                match_count <= '0;
            end else if (match_now && (match_count != '1)) begin
                match_count <= match_count + 1'b1;
            end
        end
    end

endmodule
